// File: rtl/dmem_bus_ctrl.sv
// Load/store bus controller: turns a datapath load/store into one ready/valid bus
// transaction, stalling the pipeline until the access retires in DONE.
module dmem_bus_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Mem_WrAddr,
   input  logic [31:0] Mem_WrData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr,
   output logic        BusErr,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_we,
   output logic [31:0] bus_req_addr,
   output logic [31:0] bus_req_wdata,
   output logic [3:0]  bus_req_be,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_rdata,
   input  logic        bus_rsp_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misalign_q, misalign_d;
   logic        buserr_q, buserr_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;

   logic        req;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic [3:0]  be_c;
   logic        unused_funct3;

   assign unused_funct3 = Funct3[2];

   // Size 2'b11 is treated as a word access.
   assign req        = MemRead | MemWrite;
   assign is_half    = (Funct3[1:0] == 2'b01);
   assign is_word    = Funct3[1];
   assign misaligned = (is_half & Mem_WrAddr[0]) | (is_word & (|Mem_WrAddr[1:0]));

   always_comb begin
      be_c = 4'b1111;
      if (Funct3[1:0] == 2'b00) begin
         be_c = 4'b0001 << Mem_WrAddr[1:0];
      end else if (is_half) begin
         be_c = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      misalign_d = 1'b0;
      buserr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (misaligned) begin
                  state_d    = S_DONE;
                  misalign_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  addr_d  = {Mem_WrAddr[31:2], 2'b00};
                  we_d    = MemWrite;
                  wdata_d = Mem_WrData;
                  be_d    = be_c;
               end
            end
         end
         S_REQ: begin
            if (bus_req_ready) begin
               state_d = S_WAIT;
               cnt_d   = 16'd0;
            end
         end
         S_WAIT: begin
            // A response in the final timeout cycle still wins over the timeout.
            if (bus_rsp_valid) begin
               state_d  = S_DONE;
               buserr_d = bus_rsp_err;
               if (!we_q) rdata_d = bus_rsp_rdata;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         rdata_q    <= 32'd0;
         misalign_q <= 1'b0;
         buserr_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         buserr_q   <= buserr_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
      end
   end

   assign Stall         = ((state_q == S_IDLE) & req) | (state_q == S_REQ) | (state_q == S_WAIT);
   assign bus_req_valid = (state_q == S_REQ);
   assign bus_req_we    = we_q;
   assign bus_req_addr  = addr_q;
   assign bus_req_wdata = wdata_q;
   assign bus_req_be    = be_q;
   assign ReadData      = rdata_q;
   assign MisalignErr   = misalign_q;
   assign BusErr        = buserr_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: loads, stores, misalignment, ready backpressure,
// error response, timeout and asynchronous reset during an access.
module tb_dmem_bus_ctrl;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic [31:0] ReadData;
   logic        Stall;
   logic        MisalignErr;
   logic        BusErr;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_we;
   logic [31:0] bus_req_addr;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_be;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;
   logic        bus_rsp_err;

   int n_checks = 0;
   int n_errors = 0;
   int stalls   = 0;

   dmem_bus_ctrl #(.TIMEOUT(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .Funct3        (Funct3),
      .Mem_WrAddr    (Mem_WrAddr),
      .Mem_WrData    (Mem_WrData),
      .ReadData      (ReadData),
      .Stall         (Stall),
      .MisalignErr   (MisalignErr),
      .BusErr        (BusErr),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_we    (bus_req_we),
      .bus_req_addr  (bus_req_addr),
      .bus_req_wdata (bus_req_wdata),
      .bus_req_be    (bus_req_be),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata),
      .bus_rsp_err   (bus_rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset         = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      Funct3        = 3'b000;
      Mem_WrAddr    = 32'd0;
      Mem_WrData    = 32'd0;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = 32'd0;
      bus_rsp_err   = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_readdata", ReadData, 32'd0);
      check("rst_misalign", MisalignErr, 1'b0);
      check("rst_buserr", BusErr, 1'b0);
      check("rst_valid", bus_req_valid, 1'b0);
      check("rst_stall", Stall, 1'b0);
      reset = 1'b1;
      tick();

      // 1. LW 0x100, ready at once, response in second WAIT cycle
      MemRead = 1'b1; Funct3 = 3'b010; Mem_WrAddr = 32'h100; bus_req_ready = 1'b1;
      #1;
      check("t1_idle_stall", Stall, 1'b1);
      check("t1_idle_valid", bus_req_valid, 1'b0);
      stalls += int'(Stall);
      tick();
      check("t1_req_valid", bus_req_valid, 1'b1);
      check("t1_req_addr", bus_req_addr, 32'h100);
      check("t1_req_be", bus_req_be, 4'b1111);
      check("t1_req_we", bus_req_we, 1'b0);
      stalls += int'(Stall);
      tick();
      bus_req_ready = 1'b0;
      check("t1_wait_valid", bus_req_valid, 1'b0);
      stalls += int'(Stall);
      tick();
      bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hDEADBEEF;
      stalls += int'(Stall);
      tick();
      bus_rsp_valid = 1'b0;
      check("t1_done_rdata", ReadData, 32'hDEADBEEF);
      check("t1_done_stall", Stall, 1'b0);
      check("t1_done_buserr", BusErr, 1'b0);
      check("t1_done_misalign", MisalignErr, 1'b0);
      stalls += int'(Stall);
      check("t1_stall_cycles", stalls, 4);
      tick();
      MemRead = 1'b0;
      #1;
      check("t1_idle_after", Stall, 1'b0);

      // 2. SB 0x203
      MemWrite = 1'b1; Funct3 = 3'b000; Mem_WrAddr = 32'h203; Mem_WrData = 32'hAA000000;
      bus_req_ready = 1'b1;
      tick();
      check("t2_req_valid", bus_req_valid, 1'b1);
      check("t2_req_be", bus_req_be, 4'b1000);
      check("t2_req_addr", bus_req_addr, 32'h200);
      check("t2_req_we", bus_req_we, 1'b1);
      check("t2_req_wdata", bus_req_wdata, 32'hAA000000);
      tick();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h12345678;
      tick();
      bus_rsp_valid = 1'b0;
      check("t2_done_rdata", ReadData, 32'hDEADBEEF);
      check("t2_done_buserr", BusErr, 1'b0);
      check("t2_done_misalign", MisalignErr, 1'b0);
      check("t2_done_stall", Stall, 1'b0);
      tick();
      MemWrite = 1'b0;

      // 3. LH 0x101 then LW 0x102 back to back, both misaligned
      MemRead = 1'b1; Funct3 = 3'b001; Mem_WrAddr = 32'h101;
      #1;
      check("t3a_idle_stall", Stall, 1'b1);
      check("t3a_idle_valid", bus_req_valid, 1'b0);
      tick();
      check("t3a_done_misalign", MisalignErr, 1'b1);
      check("t3a_done_valid", bus_req_valid, 1'b0);
      check("t3a_done_stall", Stall, 1'b0);
      check("t3a_done_buserr", BusErr, 1'b0);
      tick();
      Funct3 = 3'b010; Mem_WrAddr = 32'h102;
      #1;
      check("t3b_idle_misalign", MisalignErr, 1'b0);
      check("t3b_idle_stall", Stall, 1'b1);
      check("t3b_idle_valid", bus_req_valid, 1'b0);
      tick();
      check("t3b_done_misalign", MisalignErr, 1'b1);
      check("t3b_done_valid", bus_req_valid, 1'b0);
      tick();
      MemRead = 1'b0;
      #1;
      check("t3b_idle_misalign", MisalignErr, 1'b0);
      check("t3b_idle_stall", Stall, 1'b0);

      // 4. SH 0x302 with ready withheld 5 cycles, then error response
      MemWrite = 1'b1; Funct3 = 3'b001; Mem_WrAddr = 32'h302; Mem_WrData = 32'h5A5A0000;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", bus_req_valid, 1'b1);
         check("t4_hold_addr", bus_req_addr, 32'h300);
         check("t4_hold_be", bus_req_be, 4'b1100);
         check("t4_hold_stall", Stall, 1'b1);
         tick();
      end
      check("t4_still_valid", bus_req_valid, 1'b1);
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1;
      bus_rsp_rdata = 32'h0BAD0BAD;
      tick();
      bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
      check("t4_done_buserr", BusErr, 1'b1);
      check("t4_done_stall", Stall, 1'b0);
      check("t4_done_rdata", ReadData, 32'hDEADBEEF);
      tick();
      MemWrite = 1'b0;
      #1;
      check("t4_idle_buserr", BusErr, 1'b0);

      // 5. LW 0x400, no response: timeout after 8 WAIT cycles
      MemRead = 1'b1; Funct3 = 3'b010; Mem_WrAddr = 32'h400; bus_req_ready = 1'b1;
      tick();
      tick();
      bus_req_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("t5_wait_stall", Stall, 1'b1);
         check("t5_wait_buserr", BusErr, 1'b0);
         tick();
      end
      check("t5_done_buserr", BusErr, 1'b1);
      check("t5_done_stall", Stall, 1'b0);
      check("t5_done_rdata", ReadData, 32'hDEADBEEF);
      tick();
      MemRead = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hBADBAD00;
      #1;
      check("t5_idle_stall", Stall, 1'b0);
      tick();
      bus_rsp_valid = 1'b0;
      check("t5_late_buserr", BusErr, 1'b0);
      check("t5_late_rdata", ReadData, 32'hDEADBEEF);
      check("t5_late_valid", bus_req_valid, 1'b0);
      check("t5_late_stall", Stall, 1'b0);

      // 6. Asynchronous reset during WAIT
      MemRead = 1'b1; Funct3 = 3'b010; Mem_WrAddr = 32'h500; bus_req_ready = 1'b1;
      tick();
      tick();
      bus_req_ready = 1'b0;
      #1;
      check("t6_wait_stall", Stall, 1'b1);
      reset = 1'b0;
      #1;
      check("t6_rst_rdata", ReadData, 32'd0);
      check("t6_rst_valid", bus_req_valid, 1'b0);
      check("t6_rst_stall_req", Stall, 1'b1);
      MemRead = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h77777777;
      #1;
      check("t6_rst_stall_noreq", Stall, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      bus_rsp_valid = 1'b0;
      check("t6_post_rdata", ReadData, 32'd0);
      check("t6_post_buserr", BusErr, 1'b0);
      check("t6_post_stall", Stall, 1'b0);
      check("t6_post_valid", bus_req_valid, 1'b0);
      MemRead = 1'b1; Funct3 = 3'b000; Mem_WrAddr = 32'h501; bus_req_ready = 1'b1;
      #1;
      check("t6_post_stall_req", Stall, 1'b1);

      // LB 0x501 with minimum latency: response in the first WAIT cycle
      tick();
      check("t7_req_be", bus_req_be, 4'b0010);
      check("t7_req_addr", bus_req_addr, 32'h500);
      tick();
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h00005500;
      check("t7_wait_stall", Stall, 1'b1);
      tick();
      bus_rsp_valid = 1'b0;
      check("t7_done_rdata", ReadData, 32'h00005500);
      check("t7_done_stall", Stall, 1'b0);
      tick();
      MemRead = 1'b0;
      #1;
      check("t7_idle_stall", Stall, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
